// File: rtl/spi_port_arbiter_if.sv
// ============================================================================
// Module   : spi_port_arbiter_if
// Purpose  : Bundle of the SPI byte-channel and per-client signals around
//            spi_port_arbiter. The arbiter uses the slave modport; the
//            SPI slave and the client logic drive through the master modport.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_port_arbiter_if #(
  parameter int NUM_CLIENTS = 4
);
  // SPI byte-level slave side
  logic [7:0]               spi_byte_recv;
  logic                     spi_valid;
  logic                     spi_busy;
  logic                     spi_write;
  logic [7:0]               spi_byte_send;
  // Client RX side
  logic [7:0]               cl_byte_recv;
  logic [NUM_CLIENTS-1:0]   cl_valid;
  logic                     cl_sof;
  logic                     cl_eof;
  // Client TX side
  logic [NUM_CLIENTS-1:0]   cl_req;
  logic [NUM_CLIENTS-1:0]   cl_gnt;
  logic [NUM_CLIENTS-1:0]   cl_write;
  logic [8*NUM_CLIENTS-1:0] cl_byte_send;
  logic [NUM_CLIENTS-1:0]   cl_last;
  logic [NUM_CLIENTS-1:0]   cl_busy;
  // Status
  logic                     rx_err;

  modport slave (
    input  spi_byte_recv, spi_valid, spi_busy,
    input  cl_req, cl_write, cl_byte_send, cl_last,
    output spi_write, spi_byte_send,
    output cl_byte_recv, cl_valid, cl_sof, cl_eof,
    output cl_gnt, cl_busy, rx_err
  );

  modport master (
    output spi_byte_recv, spi_valid, spi_busy,
    output cl_req, cl_write, cl_byte_send, cl_last,
    input  spi_write, spi_byte_send,
    input  cl_byte_recv, cl_valid, cl_sof, cl_eof,
    input  cl_gnt, cl_busy, rx_err
  );
endinterface

`default_nettype wire

// File: rtl/spi_port_arbiter.sv
// ============================================================================
// Module   : spi_port_arbiter
// Purpose  : Shares one SPI slave byte channel between NUM_CLIENTS clients.
//            RX: parses header/length/payload frames and routes payload bytes
//            to the addressed client. TX: round-robin packet-level grant of
//            the SPI transmit byte port. RX and TX run independently.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_port_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int CID_W       = $clog2(NUM_CLIENTS)
) (
  input  wire logic         clk,
  input  wire logic         rst_L,
  spi_port_arbiter_if.slave bus
);

  localparam logic [NUM_CLIENTS-1:0] ONE_HOT0 = NUM_CLIENTS'(1);

  // --------------------------------------------------------------------------
  // RX path
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {R_HDR, R_LEN, R_DATA, R_SKIP} rx_state_t;

  rx_state_t              rx_state_q, rx_state_d;
  logic [7:0]             id_q, id_d;
  logic [7:0]             cnt_q, cnt_d;      // payload bytes still to come
  logic                   first_q, first_d;  // next payload byte is the first
  logic [NUM_CLIENTS-1:0] valid_q, valid_d;
  logic [7:0]             rbyte_q, rbyte_d;
  logic                   sof_q, sof_d;
  logic                   eof_q, eof_d;
  logic                   err_q, err_d;

  // RX state and registered client strobes
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      rx_state_q <= R_HDR;
      id_q       <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      valid_q    <= '0;
      rbyte_q    <= '0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      valid_q    <= valid_d;
      rbyte_q    <= rbyte_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      err_q      <= err_d;
    end
  end

  // RX frame parser: moves only on spi_valid, strobes are single-cycle
  always_comb begin
    rx_state_d = rx_state_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    valid_d    = '0;
    rbyte_d    = rbyte_q;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    err_d      = 1'b0;
    if (bus.spi_valid) begin
      unique case (rx_state_q)
        R_HDR: begin
          id_d       = bus.spi_byte_recv;
          rx_state_d = R_LEN;
        end
        R_LEN: begin
          cnt_d   = bus.spi_byte_recv;
          first_d = 1'b1;
          if (bus.spi_byte_recv == 8'd0) begin
            rx_state_d = R_HDR;
          end else if (id_q < 8'(NUM_CLIENTS)) begin
            rx_state_d = R_DATA;
          end else begin
            err_d      = 1'b1;
            rx_state_d = R_SKIP;
          end
        end
        R_DATA: begin
          valid_d = ONE_HOT0 << id_q[CID_W-1:0];
          rbyte_d = bus.spi_byte_recv;
          sof_d   = first_q;
          eof_d   = (cnt_q == 8'd1);
          first_d = 1'b0;
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) rx_state_d = R_HDR;
        end
        R_SKIP: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) rx_state_d = R_HDR;
        end
        default: rx_state_d = R_HDR;
      endcase
    end
  end

  assign bus.cl_valid     = valid_q;
  assign bus.cl_byte_recv = rbyte_q;
  assign bus.cl_sof       = sof_q;
  assign bus.cl_eof       = eof_q;
  assign bus.rx_err       = err_q;

  // --------------------------------------------------------------------------
  // TX path
  // --------------------------------------------------------------------------
  // T_DONE holds the grant for the cycle in which the last byte is on the SPI
  // port, so the grant drops the cycle after that byte is issued.
  typedef enum logic [1:0] {T_IDLE, T_GNT, T_DONE} tx_state_t;

  tx_state_t              tx_state_q, tx_state_d;
  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
  logic [CID_W-1:0]       gidx_q, gidx_d;    // index of the current grant
  logic [CID_W-1:0]       ptr_q, ptr_d;      // last-granted index
  logic                   sw_q, sw_d;
  logic [7:0]             sbyte_q, sbyte_d;

  logic [CID_W-1:0]       sel;
  logic                   found;
  logic [CID_W:0]         sum;
  logic [NUM_CLIENTS-1:0] busy;
  logic                   accept;

  // Round-robin pick: first requester after the last-granted index, wrapping
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    sum   = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      sum = {1'b0, ptr_q} + (CID_W+1)'(k);
      if (sum >= (CID_W+1)'(NUM_CLIENTS)) sum = sum - (CID_W+1)'(NUM_CLIENTS);
      if (!found && bus.cl_req[sum[CID_W-1:0]]) begin
        found = 1'b1;
        sel   = sum[CID_W-1:0];
      end
    end
  end

  // Busy includes the current spi_write, which keeps TX strobes one cycle apart
  assign busy   = (tx_state_q == T_IDLE) ? '0
                : (~gnt_q | {NUM_CLIENTS{bus.spi_busy | sw_q}});
  assign accept = (tx_state_q == T_GNT) && bus.cl_write[gidx_q] && !busy[gidx_q];

  // TX state and registered SPI strobe
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      tx_state_q <= T_IDLE;
      gnt_q      <= '0;
      gidx_q     <= '0;
      ptr_q      <= CID_W'(NUM_CLIENTS-1);
      sw_q       <= 1'b0;
      sbyte_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      gnt_q      <= gnt_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      sw_q       <= sw_d;
      sbyte_q    <= sbyte_d;
    end
  end

  // TX grant FSM and byte forwarding
  always_comb begin
    tx_state_d = tx_state_q;
    gnt_d      = gnt_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    sw_d       = 1'b0;
    sbyte_d    = sbyte_q;
    unique case (tx_state_q)
      T_IDLE: begin
        if (found) begin
          gnt_d      = ONE_HOT0 << sel;
          gidx_d     = sel;
          ptr_d      = sel;
          tx_state_d = T_GNT;
        end
      end
      T_GNT: begin
        if (accept) begin
          sw_d    = 1'b1;
          sbyte_d = bus.cl_byte_send[{gidx_q, 3'b000} +: 8];
          if (bus.cl_last[gidx_q]) tx_state_d = T_DONE;
        end
      end
      T_DONE: begin
        gnt_d      = '0;
        tx_state_d = T_IDLE;
      end
      default: begin
        gnt_d      = '0;
        tx_state_d = T_IDLE;
      end
    endcase
  end

  assign bus.cl_gnt        = gnt_q;
  assign bus.cl_busy       = busy;
  assign bus.spi_write     = sw_q;
  assign bus.spi_byte_send = sbyte_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_port_arbiter.sv
// ============================================================================
// Module   : tb_spi_port_arbiter
// Purpose  : Directed self-checking bench for spi_port_arbiter (4 clients).
//            Inputs change and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_port_arbiter;

  logic clk;
  logic rst_L;
  int   checks;
  int   errors;
  int   n_tx;
  logic prev_sw;

  spi_port_arbiter_if #(.NUM_CLIENTS(4)) bus ();

  spi_port_arbiter #(.NUM_CLIENTS(4)) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every SPI TX strobe is counted; two in a row is an error.
  always @(negedge clk) begin
    if (rst_L && bus.spi_write) begin
      n_tx++;
      chk("spi_write_gap", 32'(prev_sw), 32'h0);
    end
    prev_sw = bus.spi_write;
  end

  // Present one RX byte, then check the registered client outputs one cycle on.
  // Packed as {valid[3:0], sof, eof, err, data(only when valid)}.
  task automatic rx(input string tag, input logic [7:0] b, input logic [3:0] ev,
                    input logic [7:0] ed, input logic es, input logic ee, input logic er);
    logic [7:0] d;
    bus.spi_valid     = 1'b1;
    bus.spi_byte_recv = b;
    @(negedge clk);
    bus.spi_valid = 1'b0;
    d = (bus.cl_valid != 4'd0) ? bus.cl_byte_recv : 8'h00;
    chk(tag, {17'd0, bus.cl_valid, bus.cl_sof, bus.cl_eof, bus.rx_err, d},
             {17'd0, ev, es, ee, er, ((ev != 4'd0) ? ed : 8'h00)});
  endtask

  task automatic wait_gnt(input string tag, input int c);
    for (int i = 0; i < 20; i++) begin
      if (bus.cl_gnt != 4'd0) break;
      @(negedge clk);
    end
    chk(tag, 32'(bus.cl_gnt), 32'(1) << c);
  endtask

  // Client c writes one byte once it is not busy; checks it on the SPI port.
  task automatic tx_send(input string tag, input int c, input logic [7:0] b, input logic last);
    int w;
    w = 0;
    while (bus.cl_busy[c] && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.cl_write[c]             = 1'b1;
    bus.cl_last[c]              = last;
    bus.cl_byte_send[8*c +: 8]  = b;
    @(negedge clk);
    bus.cl_write[c] = 1'b0;
    bus.cl_last[c]  = 1'b0;
    chk(tag, {23'd0, bus.spi_write, bus.spi_byte_send}, {23'd0, 1'b1, b});
    if (last) begin
      @(negedge clk);
      chk({tag, "_release"}, 32'(bus.cl_gnt), 32'h0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_tx   = 0;
    prev_sw = 1'b0;
    rst_L  = 1'b0;
    bus.spi_byte_recv = '0;
    bus.spi_valid     = 1'b0;
    bus.spi_busy      = 1'b0;
    bus.cl_req        = '0;
    bus.cl_write      = '0;
    bus.cl_byte_send  = '0;
    bus.cl_last       = '0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", {13'd0, bus.cl_valid, bus.cl_gnt, bus.cl_busy, bus.spi_write,
                          bus.cl_sof, bus.cl_eof, bus.rx_err, bus.spi_byte_send}, 32'h0);
    rst_L = 1'b1;
    @(negedge clk);

    // RX routing to client 2
    rx("rx_hdr2",  8'h02, 4'b0000, 8'h00, 0, 0, 0);
    rx("rx_len3",  8'h03, 4'b0000, 8'h00, 0, 0, 0);
    rx("rx_aa",    8'hAA, 4'b0100, 8'hAA, 1, 0, 0);
    rx("rx_bb",    8'hBB, 4'b0100, 8'hBB, 0, 0, 0);
    rx("rx_cc",    8'hCC, 4'b0100, 8'hCC, 0, 1, 0);

    // Bad id: error pulse, payload skipped
    rx("bad_hdr",  8'h07, 4'b0000, 8'h00, 0, 0, 0);
    rx("bad_len",  8'h02, 4'b0000, 8'h00, 0, 0, 1);
    rx("bad_p0",   8'h11, 4'b0000, 8'h00, 0, 0, 0);
    rx("bad_p1",   8'h22, 4'b0000, 8'h00, 0, 0, 0);
    // Zero length then a one-byte frame
    rx("z_hdr",    8'h01, 4'b0000, 8'h00, 0, 0, 0);
    rx("z_len",    8'h00, 4'b0000, 8'h00, 0, 0, 0);
    rx("one_hdr",  8'h01, 4'b0000, 8'h00, 0, 0, 0);
    rx("one_len",  8'h01, 4'b0000, 8'h00, 0, 0, 0);
    rx("one_5a",   8'h5A, 4'b0010, 8'h5A, 1, 1, 0);

    // TX round-robin with requests 1011 held: expect 0,1,3,0
    bus.cl_req = 4'b1011;
    begin
      int order[4];
      order = '{0, 1, 3, 0};
      for (int i = 0; i < 4; i++) begin
        wait_gnt($sformatf("rr_gnt%0d", i), order[i]);
        if (i == 3) bus.cl_req = 4'b0000;
        tx_send($sformatf("rr%0d_b0", i), order[i], 8'(order[i] * 16), 1'b0);
        tx_send($sformatf("rr%0d_b1", i), order[i], 8'(order[i] * 16 + 1), 1'b1);
      end
    end

    // Backpressure on client 2
    bus.cl_req = 4'b0100;
    wait_gnt("bp_gnt", 2);
    bus.cl_req = 4'b0000;
    tx_send("bp_b0", 2, 8'hB0, 1'b0);
    bus.spi_busy               = 1'b1;
    bus.cl_write[2]            = 1'b1;
    bus.cl_byte_send[23:16]    = 8'hB1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {30'd0, bus.spi_write, bus.cl_busy[2]}, 32'h1);
    end
    bus.spi_busy = 1'b0;
    @(negedge clk);
    bus.cl_write[2] = 1'b0;
    chk("bp_resume", {23'd0, bus.spi_write, bus.spi_byte_send}, {23'd0, 1'b1, 8'hB1});
    tx_send("bp_b2", 2, 8'hB2, 1'b1);

    // Full duplex: RX frame to client 0 during client 3 TX, plus illegal write
    fork
      begin
        rx("fd_hdr", 8'h00, 4'b0000, 8'h00, 0, 0, 0);
        rx("fd_len", 8'h02, 4'b0000, 8'h00, 0, 0, 0);
        rx("fd_c1",  8'hC1, 4'b0001, 8'hC1, 1, 0, 0);
        rx("fd_c2",  8'hC2, 4'b0001, 8'hC2, 0, 1, 0);
      end
      begin
        bus.cl_req = 4'b1000;
        wait_gnt("fd_gnt", 3);
        bus.cl_write[1]        = 1'b1;
        bus.cl_byte_send[15:8] = 8'hEE;
        @(negedge clk);
        bus.cl_write[1] = 1'b0;
        chk("illegal_wr", {30'd0, bus.spi_write, 1'b0}, 32'h0);
        tx_send("fd_d0", 3, 8'hD0, 1'b0);
        bus.cl_req = 4'b0000;
        tx_send("fd_d1", 3, 8'hD1, 1'b0);
        chk("fd_gnt_hold", 32'(bus.cl_gnt), 32'h8);
        tx_send("fd_d2", 3, 8'hD2, 1'b1);
      end
    join

    // Async reset mid-packet (client 1) and mid-frame (client 0)
    bus.cl_req = 4'b0010;
    wait_gnt("rst_gnt", 1);
    tx_send("rst_b0", 1, 8'h5B, 1'b0);
    rx("rst_hdr", 8'h00, 4'b0000, 8'h00, 0, 0, 0);
    rx("rst_len", 8'h03, 4'b0000, 8'h00, 0, 0, 0);
    rx("rst_p0",  8'h11, 4'b0001, 8'h11, 1, 0, 0);
    #2;
    rst_L = 1'b0;
    #1;
    chk("async_rst", {13'd0, bus.cl_valid, bus.cl_gnt, bus.cl_busy, bus.spi_write,
                      bus.cl_sof, bus.cl_eof, bus.rx_err, bus.cl_byte_recv}, 32'h0);
    bus.cl_req = 4'b0000;
    @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
    rx("post_hdr", 8'h00, 4'b0000, 8'h00, 0, 0, 0);
    rx("post_len", 8'h01, 4'b0000, 8'h00, 0, 0, 0);
    rx("post_77",  8'h77, 4'b0001, 8'h77, 1, 1, 0);
    chk("post_gnt", 32'(bus.cl_gnt), 32'h0);
    chk("tx_count", 32'(n_tx), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
